rc4_multicore_search_ctrl: RTL

//  Top-level key-search sequencer for the RC4 cracker, generalised to N_CORES parallel decrypt cores.

---
 rtl/rc4_multicore_search_ctrl.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/rc4_multicore_search_ctrl.sv
// rc4_multicore_search_ctrl
// Key-search sequencer for an RC4 cracker with N_CORES parallel decrypt cores.
// The key range [lower, upper] is interleaved across cores: core c tests
// lower+c, lower+c+N_CORES, ... Each core is walked through
// INIT -> KSA -> DECRYPT -> CHECK with one-cycle start pulses and finish
// handshakes. The first found key, or an external stop, aborts every core.

module rc4_multicore_search_ctrl #(
  parameter int KEY_W   = 24,
  parameter int N_CORES = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       go,
  input  logic [KEY_W-1:0]           lower_key_index,
  input  logic [KEY_W-1:0]           upper_key_index,
  input  logic                       stop_search,
  output logic [N_CORES-1:0]         start_init,
  input  logic [N_CORES-1:0]         finish_init,
  output logic [N_CORES-1:0]         start_ksa,
  input  logic [N_CORES-1:0]         finish_ksa,
  output logic [N_CORES-1:0]         start_decrypt,
  input  logic [N_CORES-1:0]         finish_decrypt,
  output logic [N_CORES-1:0]         start_check,
  input  logic [N_CORES-1:0]         finish_check,
  input  logic [N_CORES-1:0]         key_found,
  output logic [N_CORES*KEY_W-1:0]   current_key,
  output logic [N_CORES*3-1:0]       operation_num,
  output logic [KEY_W-1:0]           successful_key,
  output logic                       key_found_any,
  output logic                       search_done,
  output logic                       busy
);

  // Encodings double as the externally visible operation_num phase code.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_INIT    = 3'd1,
    ST_KSA     = 3'd2,
    ST_DECRYPT = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ABORT   = 3'd6
  } core_state_e;

  // Key stride between successive keys of one core, one bit wider than a key
  // so that stepping past the top of the key space cannot wrap.
  localparam logic [KEY_W:0] KEY_STEP = (KEY_W+1)'(N_CORES);

  core_state_e        state_q [N_CORES];
  core_state_e        state_d [N_CORES];
  logic [KEY_W-1:0]   key_q   [N_CORES];
  logic [KEY_W-1:0]   key_d   [N_CORES];

  logic [N_CORES-1:0] start_init_q, start_init_d;
  logic [N_CORES-1:0] start_ksa_q, start_ksa_d;
  logic [N_CORES-1:0] start_decrypt_q, start_decrypt_d;
  logic [N_CORES-1:0] start_check_q, start_check_d;

  // Only the upper bound is needed after go; the lower bound is consumed
  // immediately when the per-core starting keys are loaded.
  logic [KEY_W-1:0]   upper_q, upper_d;
  logic [KEY_W-1:0]   successful_key_q, successful_key_d;
  logic               key_found_any_q, key_found_any_d;
  logic               search_done_q, search_done_d;
  logic               busy_q, busy_d;

  logic [N_CORES-1:0] acc_init_s;
  logic [N_CORES-1:0] acc_ksa_s;
  logic [N_CORES-1:0] acc_decrypt_s;
  logic [N_CORES-1:0] acc_check_s;
  logic [N_CORES-1:0] found_vec_s;
  logic               found_any_s;
  logic [KEY_W-1:0]   win_key_s;
  logic               all_term_s;
  logic [KEY_W:0]     cand_key_s;
  logic [KEY_W:0]     next_key_s;

  // Finish acceptance: a finish counts only after the start cycle of the phase.
  always_comb begin
    acc_init_s    = '0;
    acc_ksa_s     = '0;
    acc_decrypt_s = '0;
    acc_check_s   = '0;
    for (int c = 0; c < N_CORES; c++) begin
      acc_init_s[c]    = (state_q[c] == ST_INIT)    && !start_init_q[c]    && finish_init[c];
      acc_ksa_s[c]     = (state_q[c] == ST_KSA)     && !start_ksa_q[c]     && finish_ksa[c];
      acc_decrypt_s[c] = (state_q[c] == ST_DECRYPT) && !start_decrypt_q[c] && finish_decrypt[c];
      acc_check_s[c]   = (state_q[c] == ST_CHECK)   && !start_check_q[c]   && finish_check[c];
    end
    found_vec_s = acc_check_s & key_found;
    found_any_s = |found_vec_s;
  end

  // Winner selection: scan from the top so the lowest core index wins.
  always_comb begin
    win_key_s = '0;
    for (int c = N_CORES - 1; c >= 0; c--) begin
      if (found_vec_s[c]) begin
        win_key_s = key_q[c];
      end else begin
        win_key_s = win_key_s;
      end
    end
  end

  // Completion detect: every core parked in DONE or ABORT while searching.
  always_comb begin
    all_term_s = busy_q;
    for (int c = 0; c < N_CORES; c++) begin
      if ((state_q[c] != ST_DONE) && (state_q[c] != ST_ABORT)) begin
        all_term_s = 1'b0;
      end else begin
        all_term_s = all_term_s;
      end
    end
  end

  // Next-state logic for the search controller and all per-core phase FSMs.
  always_comb begin
    state_d          = state_q;
    key_d            = key_q;
    start_init_d     = '0;
    start_ksa_d      = '0;
    start_decrypt_d  = '0;
    start_check_d    = '0;
    upper_d          = upper_q;
    successful_key_d = successful_key_q;
    key_found_any_d  = key_found_any_q;
    search_done_d    = search_done_q;
    busy_d           = busy_q;
    cand_key_s       = '0;
    next_key_s       = '0;

    if (!busy_q) begin
      if (go) begin
        upper_d          = upper_key_index;
        successful_key_d = '0;
        key_found_any_d  = 1'b0;
        search_done_d    = 1'b0;
        busy_d           = 1'b1;
        for (int c = 0; c < N_CORES; c++) begin
          // Widened sum so a lower bound near the top of the key space
          // cannot wrap around and sneak under the upper bound.
          cand_key_s = {1'b0, lower_key_index} + (KEY_W+1)'(c);
          if (cand_key_s <= {1'b0, upper_key_index}) begin
            state_d[c]      = ST_INIT;
            key_d[c]        = cand_key_s[KEY_W-1:0];
            start_init_d[c] = 1'b1;
          end else begin
            state_d[c]      = ST_DONE;
            key_d[c]        = '0;
          end
        end
      end else begin
        busy_d = 1'b0;
      end
    end else if (all_term_s) begin
      search_done_d = 1'b1;
      busy_d        = 1'b0;
      for (int c = 0; c < N_CORES; c++) begin
        state_d[c] = ST_IDLE;
      end
    end else if (found_any_s) begin
      // A find takes priority over a concurrent stop so the key is recorded.
      successful_key_d = win_key_s;
      key_found_any_d  = 1'b1;
      for (int c = 0; c < N_CORES; c++) begin
        state_d[c] = ST_ABORT;
      end
    end else if (stop_search) begin
      for (int c = 0; c < N_CORES; c++) begin
        state_d[c] = ST_ABORT;
      end
    end else begin
      for (int c = 0; c < N_CORES; c++) begin
        case (state_q[c])
          ST_INIT: begin
            if (acc_init_s[c]) begin
              state_d[c]     = ST_KSA;
              start_ksa_d[c] = 1'b1;
            end else begin
              state_d[c] = ST_INIT;
            end
          end
          ST_KSA: begin
            if (acc_ksa_s[c]) begin
              state_d[c]         = ST_DECRYPT;
              start_decrypt_d[c] = 1'b1;
            end else begin
              state_d[c] = ST_KSA;
            end
          end
          ST_DECRYPT: begin
            if (acc_decrypt_s[c]) begin
              state_d[c]       = ST_CHECK;
              start_check_d[c] = 1'b1;
            end else begin
              state_d[c] = ST_DECRYPT;
            end
          end
          ST_CHECK: begin
            if (acc_check_s[c]) begin
              next_key_s = {1'b0, key_q[c]} + KEY_STEP;
              if (next_key_s > {1'b0, upper_q}) begin
                state_d[c] = ST_DONE;
              end else begin
                state_d[c]      = ST_INIT;
                key_d[c]        = next_key_s[KEY_W-1:0];
                start_init_d[c] = 1'b1;
              end
            end else begin
              state_d[c] = ST_CHECK;
            end
          end
          default: begin
            state_d[c] = state_q[c];
          end
        endcase
      end
    end
  end

  // State register: asynchronous reset returns every core to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < N_CORES; c++) begin
        state_q[c] <= ST_IDLE;
        key_q[c]   <= '0;
      end
      start_init_q     <= '0;
      start_ksa_q      <= '0;
      start_decrypt_q  <= '0;
      start_check_q    <= '0;
      upper_q          <= '0;
      successful_key_q <= '0;
      key_found_any_q  <= 1'b0;
      search_done_q    <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      for (int c = 0; c < N_CORES; c++) begin
        state_q[c] <= state_d[c];
        key_q[c]   <= key_d[c];
      end
      start_init_q     <= start_init_d;
      start_ksa_q      <= start_ksa_d;
      start_decrypt_q  <= start_decrypt_d;
      start_check_q    <= start_check_d;
      upper_q          <= upper_d;
      successful_key_q <= successful_key_d;
      key_found_any_q  <= key_found_any_d;
      search_done_q    <= search_done_d;
      busy_q           <= busy_d;
    end
  end

  // Output packing: every output comes straight from a flop.
  always_comb begin
    current_key   = '0;
    operation_num = '0;
    for (int c = 0; c < N_CORES; c++) begin
      current_key[c*KEY_W +: KEY_W] = key_q[c];
      operation_num[c*3 +: 3]       = state_q[c];
    end
  end

  assign start_init     = start_init_q;
  assign start_ksa      = start_ksa_q;
  assign start_decrypt  = start_decrypt_q;
  assign start_check    = start_check_q;
  assign successful_key = successful_key_q;
  assign key_found_any  = key_found_any_q;
  assign search_done    = search_done_q;
  assign busy           = busy_q;

endmodule
